// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-requester round-robin arbiter/sequencer for SRAM port 0 (RW).
// Optional power-up clear of the macro is compiled in with `define SRAM_ARB_CLEAR_EN.
module sram_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_valid,
  output logic                  m0_req_ready,
  input  logic                  m0_req_we,
  input  logic [ADDR_WIDTH-1:0] m0_req_addr,
  input  logic [NUM_WMASKS-1:0] m0_req_wmask,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  output logic                  m0_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  input  logic                  m1_req_valid,
  output logic                  m1_req_ready,
  input  logic                  m1_req_we,
  input  logic [ADDR_WIDTH-1:0] m1_req_addr,
  input  logic [NUM_WMASKS-1:0] m1_req_wmask,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  init_done
);

`ifdef SRAM_ARB_CLEAR_EN
  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;
  localparam state_t RESET_STATE = ST_CLEAR;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clr_issue;
`else
  typedef enum logic [0:0] {ST_RUN = 1'b1} state_t;
  localparam state_t RESET_STATE = ST_RUN;
`endif

  state_t state_q, state_d;
  logic [1:0] grant;
  logic       rr;
  logic       accept, sel;
  logic       sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [NUM_WMASKS-1:0] sel_wmask;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [1:0] tag_valid, tag_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  // rst_n gates grant so ready/init_done read as 0 while reset is held.
  always_comb begin
    state_d = state_q;
    grant   = 2'b00;
`ifdef SRAM_ARB_CLEAR_EN
    clr_issue = 1'b0;
`endif
    case (state_q)
`ifdef SRAM_ARB_CLEAR_EN
      ST_CLEAR: begin
        clr_issue = rst_n;
        if (clr_cnt == '1) state_d = ST_RUN;
      end
`endif
      ST_RUN: begin
        if (rst_n) begin
          grant[0] = m0_req_valid & (~m1_req_valid | ~rr);
          grant[1] = m1_req_valid & (~m0_req_valid |  rr);
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  assign m0_req_ready = grant[0];
  assign m1_req_ready = grant[1];
  assign init_done    = rst_n & (state_q == ST_RUN);
  assign accept       = |grant;
  assign sel          = grant[1];
  assign sel_we       = sel ? m1_req_we    : m0_req_we;
  assign sel_addr     = sel ? m1_req_addr  : m0_req_addr;
  assign sel_wmask    = sel ? m1_req_wmask : m0_req_wmask;
  assign sel_wdata    = sel ? m1_req_wdata : m0_req_wdata;

`ifdef SRAM_ARB_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         clr_cnt <= '0;
    else if (clr_issue) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      rr          <= 1'b0;
    end else begin
      sram_csb0 <= 1'b1;
      sram_web0 <= 1'b1;
`ifdef SRAM_ARB_CLEAR_EN
      if (clr_issue) begin
        sram_csb0   <= 1'b0;
        sram_web0   <= 1'b0;
        sram_wmask0 <= '1;
        sram_addr0  <= clr_cnt;
        sram_din0   <= '0;
      end else
`endif
      if (accept) begin
        sram_csb0   <= 1'b0;
        sram_web0   <= ~sel_we;
        sram_wmask0 <= sel_we ? sel_wmask : '0;
        sram_addr0  <= sel_addr;
        sram_din0   <= sel_wdata;
        rr          <= ~sel;
      end
    end
  end

  // Stage 0 matches the SRAM sample edge, stage 1 the edge where dout0 is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid    <= '0;
      tag_owner    <= '0;
      m0_rsp_valid <= 1'b0;
      m1_rsp_valid <= 1'b0;
      m0_rsp_rdata <= '0;
      m1_rsp_rdata <= '0;
    end else begin
      tag_valid    <= {tag_valid[0], accept & ~sel_we};
      tag_owner    <= {tag_owner[0], sel};
      m0_rsp_valid <= 1'b0;
      m1_rsp_valid <= 1'b0;
      if (tag_valid[1]) begin
        if (tag_owner[1]) begin
          m1_rsp_valid <= 1'b1;
          m1_rsp_rdata <= sram_dout0;
        end else begin
          m0_rsp_valid <= 1'b1;
          m0_rsp_rdata <= sram_dout0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter with a behavioural 1rw SRAM port.
module tb_sram_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req_valid = 0, m0_req_ready, m0_req_we = 0;
  logic [7:0]  m0_req_addr = 0;
  logic [3:0]  m0_req_wmask = 0;
  logic [31:0] m0_req_wdata = 0;
  logic        m0_rsp_valid;
  logic [31:0] m0_rsp_rdata;
  logic        m1_req_valid = 0, m1_req_ready, m1_req_we = 0;
  logic [7:0]  m1_req_addr = 0;
  logic [3:0]  m1_req_wmask = 0;
  logic [31:0] m1_req_wdata = 0;
  logic        m1_rsp_valid;
  logic [31:0] m1_rsp_rdata;
  logic        sram_csb0, sram_web0, init_done;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0 = 32'h0;

  sram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
    .m0_req_addr(m0_req_addr), .m0_req_wmask(m0_req_wmask), .m0_req_wdata(m0_req_wdata),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
    .m1_req_addr(m1_req_addr), .m1_req_wmask(m1_req_wmask), .m1_req_wdata(m1_req_wdata),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .init_done(init_done)
  );

  // Macro port 0: samples pins on posedge, writes or drives dout on the following negedge.
  logic [31:0] mem [0:255];
  logic        s_csb = 1'b1, s_web = 1'b1;
  logic [3:0]  s_wm = 0;
  logic [7:0]  s_addr = 0;
  logic [31:0] s_din = 0;
  always @(posedge clk) begin
    s_csb <= sram_csb0; s_web <= sram_web0; s_wm <= sram_wmask0;
    s_addr <= sram_addr0; s_din <= sram_din0;
  end
  always @(negedge clk) begin
    if (!s_csb) begin
      if (!s_web) begin
        for (int b = 0; b < 4; b++)
          if (s_wm[b]) mem[s_addr][b*8 +: 8] <= s_din[b*8 +: 8];
      end else begin
        sram_dout0 <= mem[s_addr];
      end
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload;
    mem[8'h02] = 32'hfa010113;
    mem[8'h10] = 32'h00000000;
    mem[8'h20] = 32'h20202020;
    mem[8'h21] = 32'h21212121;
  endtask

  task automatic wait_init;
    int k = 0;
    while (init_done !== 1'b1 && k < 400) begin tick; k++; end
    chk("init_wait", init_done, 1);
  endtask

  task automatic rd(input logic own, input logic [7:0] a, input logic [31:0] exp, input string tag);
    if (own) begin m1_req_valid = 1; m1_req_we = 0; m1_req_addr = a; end
    else     begin m0_req_valid = 1; m0_req_we = 0; m0_req_addr = a; end
    #1;
    chk({tag, "_ready"}, own ? m1_req_ready : m0_req_ready, 1);
    tick;
    m0_req_valid = 0; m1_req_valid = 0;
    chk({tag, "_csb"}, sram_csb0, 0);
    chk({tag, "_addr"}, sram_addr0, a);
    tick;
    chk({tag, "_early"}, own ? m1_rsp_valid : m0_rsp_valid, 0);
    tick;
    chk({tag, "_strobe"}, own ? m1_rsp_valid : m0_rsp_valid, 1);
    chk({tag, "_rdata"}, own ? m1_rsp_rdata : m0_rsp_rdata, exp);
    chk({tag, "_other"}, own ? m0_rsp_valid : m1_rsp_valid, 0);
    tick;
    chk({tag, "_once"}, own ? m1_rsp_valid : m0_rsp_valid, 0);
  endtask

  initial begin
    int bad, n0, n1;
    logic e0, e1;
    for (int i = 0; i < 256; i++) mem[i] = 32'hdead0000 | i;
    preload();

    m0_req_valid = 1; m1_req_valid = 1;
    tick;
    chk("rst_csb", sram_csb0, 1);
    chk("rst_web", sram_web0, 1);
    chk("rst_wmask", sram_wmask0, 0);
    chk("rst_addr", sram_addr0, 0);
    chk("rst_din", sram_din0, 0);
    chk("rst_ready", {m0_req_ready, m1_req_ready}, 0);
    chk("rst_rsp", {m0_rsp_valid, m1_rsp_valid}, 0);
    chk("rst_rdata", m0_rsp_rdata | m1_rsp_rdata, 0);
    chk("rst_init", init_done, 0);
    m0_req_valid = 0; m1_req_valid = 0;
    rst_n = 1;
    #1;
`ifdef SRAM_ARB_CLEAR_EN
    chk("init_after_rel", init_done, 0);
    m0_req_valid = 1; m0_req_we = 0; m0_req_addr = 8'h8c;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (m0_req_ready !== 1'b0 || init_done !== 1'b0) bad++;
      tick;
    end
    chk("clear_hold", bad, 0);
    chk("clear_done", init_done, 1);
    rd(0, 8'h8c, 32'h0, "clear_rd");
    preload();
`else
    chk("init_after_rel", init_done, 1);
`endif

    rd(0, 8'h02, 32'hfa010113, "rd0");

    m1_req_valid = 1; m1_req_we = 1; m1_req_addr = 8'h10;
    m1_req_wmask = 4'b0101; m1_req_wdata = 32'haabbccdd;
    #1;
    chk("wr_ready", m1_req_ready, 1);
    tick;
    chk("wr_web", sram_web0, 0);
    chk("wr_wmask", sram_wmask0, 4'b0101);
    chk("wr_din", sram_din0, 32'haabbccdd);
    m1_req_we = 0;
    #1;
    chk("raw_ready", m1_req_ready, 1);
    tick;
    m1_req_valid = 0;
    chk("raw_wmask", sram_wmask0, 0);
    tick;
    tick;
    chk("raw_strobe", m1_rsp_valid, 1);
    chk("raw_rdata", m1_rsp_rdata, 32'h00bb00dd);
    chk("raw_m0", m0_rsp_valid, 0);
    tick;

    n0 = 0; n1 = 0;
    m0_req_we = 0; m1_req_we = 0; m0_req_addr = 8'h20; m1_req_addr = 8'h21;
    for (int j = 0; j < 8; j++) begin
      m0_req_valid = (j < 6); m1_req_valid = (j < 6);
      #1;
      if (j < 6) begin
        chk("cont_rdy0", m0_req_ready, (j % 2) == 0);
        chk("cont_rdy1", m1_req_ready, (j % 2) == 1);
      end
      tick;
      chk("cont_csb", sram_csb0, (j < 6) ? 0 : 1);
      if (j < 6) chk("cont_addr", sram_addr0, (j % 2) ? 8'h21 : 8'h20);
      e0 = (j >= 2) && ((j - 2) % 2 == 0);
      e1 = (j >= 2) && ((j - 2) % 2 == 1);
      chk("cont_rsp0", m0_rsp_valid, e0);
      chk("cont_rsp1", m1_rsp_valid, e1);
      if (e0) chk("cont_rdata0", m0_rsp_rdata, 32'h20202020);
      if (e1) chk("cont_rdata1", m1_rsp_rdata, 32'h21212121);
      n0 += m0_rsp_valid; n1 += m1_rsp_valid;
    end
    m0_req_valid = 0; m1_req_valid = 0;
    chk("cont_n0", n0, 3);
    chk("cont_n1", n1, 3);
    tick;

    m0_req_valid = 1; m0_req_addr = 8'h02;
    tick;
    m0_req_valid = 0;
    tick;
    rst_n = 0;
    m1_req_valid = 1; m1_req_addr = 8'h21;
    #1;
    chk("mid_csb", sram_csb0, 1);
    chk("mid_init", init_done, 0);
    chk("mid_ready", m1_req_ready, 0);
    chk("mid_rdata", m0_rsp_rdata, 0);
    bad = 0;
    for (int i = 0; i < 2; i++) begin
      tick;
      if (m0_rsp_valid !== 1'b0 || m1_rsp_valid !== 1'b0) bad++;
    end
    rst_n = 1;
    m1_req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (m0_rsp_valid !== 1'b0 || m1_rsp_valid !== 1'b0) bad++;
    end
    chk("mid_no_rsp", bad, 0);
`ifdef SRAM_ARB_CLEAR_EN
    wait_init();
    preload();
`endif
    rd(1, 8'h21, 32'h21212121, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
